ks_note_sequencer: RTL and testbench

- Upstream pattern sequencer for the Karplus-Strong string voice.
- Steps through a small register-file pattern of string periods. At each step it drives the period, then issues a pluck pulse of configurable width.
- Outputs feed the ks_string pluck and period inputs directly; timing runs on the KS sample clock.
- Pattern and timing come from the SPI register map: writes go through the wr_* port, timing through static config inputs.

---
 rtl/ks_note_sequencer_if.sv | 13 +
 rtl/ks_note_sequencer.sv | 119 +++++++++++
 tb/tb_ks_note_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ks_note_sequencer_if.sv
// Pattern write bus from the SPI register map into the note sequencer.
// The register-map side drives through master; the sequencer listens through slave.
interface ks_note_sequencer_if #(
    parameter int SW         = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  wr_en_i;
    logic [SW-1:0]         wr_addr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;

    modport master (output wr_en_i, wr_addr_i, wr_data_i);
    modport slave  (input  wr_en_i, wr_addr_i, wr_data_i);
endinterface

// File: rtl/ks_note_sequencer.sv
// Pattern sequencer for the Karplus-Strong string voice: steps through a small
// period pattern, driving period_o and a pluck pulse of configurable width per step.
module ks_note_sequencer #(
    parameter int NUM_STEPS   = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int TEMPO_WIDTH = 16,
    parameter int PLUCK_WIDTH = 4,
    localparam int SW         = $clog2(NUM_STEPS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   loop_i,
    input  logic [TEMPO_WIDTH-1:0] tempo_i,
    input  logic [PLUCK_WIDTH-1:0] pluck_len_i,
    input  logic [SW-1:0]          last_step_i,
    ks_note_sequencer_if.slave     wr,
    output logic [DATA_WIDTH-1:0]  period_o,
    output logic                   pluck_o,
    output logic [SW-1:0]          step_o,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  mem [NUM_STEPS];
    logic [TEMPO_WIDTH-1:0] tcnt;
    logic [PLUCK_WIDTH-1:0] pcnt;

    logic                   start_req;
    logic [SW-1:0]          start_idx;
    logic                   finish;
    logic [DATA_WIDTH-1:0]  start_word;
    logic [PLUCK_WIDTH-1:0] pluck_len_eff;

    // Step-start decision: leaving IDLE, or a step boundary (tcnt hit zero) in RUN.
    always_comb begin
        start_req = 1'b0;
        start_idx = '0;
        finish    = 1'b0;
        case (state)
            IDLE: start_req = en_i;
            RUN: begin
                if (tcnt == '0 && en_i) begin
                    if (step_o != last_step_i) begin
                        start_req = 1'b1;
                        start_idx = step_o + SW'(1);
                    end else if (loop_i) begin
                        start_req = 1'b1;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign start_word    = mem[start_idx];
    assign pluck_len_eff = (pluck_len_i == '0) ? PLUCK_WIDTH'(1) : pluck_len_i;

    // The read above sees the pre-edge word, so a same-edge write lands for the next pass.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr.wr_en_i) begin
            mem[wr.wr_addr_i] <= wr.wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            period_o <= '0;
            pluck_o  <= 1'b0;
            step_o   <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            tcnt     <= '0;
            pcnt     <= '0;
        end else begin
            done_o <= finish;
            if (start_req) begin
                state   <= RUN;
                busy_o  <= 1'b1;
                step_o  <= start_idx;
                // A rest keeps the previous period so the string never sees a zero period.
                if (start_word != '0) begin
                    period_o <= start_word;
                end
                tcnt    <= tempo_i;
                pluck_o <= (start_word != '0) && (tempo_i != '0);
                pcnt    <= pluck_len_eff - PLUCK_WIDTH'(1);
            end else if (state == RUN) begin
                if (tcnt == '0) begin
                    state   <= IDLE;
                    busy_o  <= 1'b0;
                    pluck_o <= 1'b0;
                end else begin
                    tcnt <= tcnt - TEMPO_WIDTH'(1);
                    // Dropping at tcnt==1 guarantees a low cycle before the next pluck.
                    if (pcnt == '0 || tcnt == TEMPO_WIDTH'(1)) begin
                        pluck_o <= 1'b0;
                    end else begin
                        pcnt <= pcnt - PLUCK_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Self-checking bench for ks_note_sequencer against a step/position-level reference model.
module tb_ks_note_sequencer;

    localparam int NS = 8;
    localparam int DW = 8;
    localparam int TW = 16;
    localparam int PW = 4;
    localparam int SW = 3;
    localparam int VW = DW + SW + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          loop_sel;
    logic [TW-1:0] tempo;
    logic [PW-1:0] pluck_len;
    logic [SW-1:0] last_step;
    logic          wr_en;
    logic [SW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] period_o;
    logic          pluck_o;
    logic [SW-1:0] step_o;
    logic          busy_o;
    logic          done_o;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: position within the current step counts up from 0.
    logic [DW-1:0] m_mem [NS];
    logic          m_busy;
    logic [SW-1:0] m_step;
    logic [DW-1:0] m_period;
    logic          m_done;
    int            m_pos;
    int            m_len;
    int            m_phigh;

    always #5 clk = ~clk;

    ks_note_sequencer_if #(.SW(SW), .DATA_WIDTH(DW)) wr_bus ();

    assign wr_bus.wr_en_i   = wr_en;
    assign wr_bus.wr_addr_i = wr_addr;
    assign wr_bus.wr_data_i = wr_data;

    ks_note_sequencer #(
        .NUM_STEPS  (NS),
        .DATA_WIDTH (DW),
        .TEMPO_WIDTH(TW),
        .PLUCK_WIDTH(PW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .loop_i     (loop_sel),
        .tempo_i    (tempo),
        .pluck_len_i(pluck_len),
        .last_step_i(last_step),
        .wr         (wr_bus),
        .period_o   (period_o),
        .pluck_o    (pluck_o),
        .step_o     (step_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    task automatic model_start(input logic [SW-1:0] s);
        int plen;
        int tp;
        tp   = int'(tempo);
        plen = (pluck_len == '0) ? 1 : int'(pluck_len);
        m_busy  = 1'b1;
        m_step  = s;
        m_pos   = 0;
        m_len   = tp + 1;
        m_phigh = (m_mem[s] != '0 && tp != 0) ? ((plen < tp) ? plen : tp) : 0;
        if (m_mem[s] != '0) m_period = m_mem[s];
    endtask

    task automatic model_edge();
        logic [SW-1:0] nxt;
        if (rst) begin
            for (int i = 0; i < NS; i++) m_mem[i] = '0;
            m_busy = 1'b0; m_step = '0; m_period = '0; m_done = 1'b0;
            m_pos = 0; m_len = 1; m_phigh = 0;
            return;
        end
        m_done = 1'b0;
        if (!m_busy) begin
            if (en) model_start('0);
        end else if (m_pos == m_len - 1) begin
            if (!en) begin
                m_busy = 1'b0;
            end else if (m_step != last_step) begin
                nxt = m_step + SW'(1);
                model_start(nxt);
            end else if (loop_sel) begin
                model_start('0);
            end else begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else begin
            m_pos++;
        end
        if (wr_en) m_mem[wr_addr] = wr_data;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic pl;
        pl = m_busy && (m_pos < m_phigh);
        return {m_period, pl, m_step, m_busy, m_done};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; wr_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_word(input logic [SW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_std();
        write_word(3'd0, 8'd40);
        write_word(3'd1, 8'd0);
        write_word(3'd2, 8'd60);
        write_word(3'd3, 8'd80);
        last_step = 3'd3; tempo = 16'd9; pluck_len = 4'd3;
    endtask

    task automatic test_reset();
        logic [VW-1:0] obs;
        rst = 1'b1; en = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'd55;
        tick();
        obs = {period_o, pluck_o, step_o, busy_o, done_o};
        compared++;
        if (obs !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs got=%h want=0", obs);
        end
        wr_en = 1'b0; en = 1'b0; rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            obs = {period_o, pluck_o, step_o, busy_o, done_o};
            compared++;
            if (obs !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL reset_idle k=%0d got=%h want=%h", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_one_shot();
        logic [VW-1:0] obs;
        int dones = 0;
        int highs = 0;
        do_reset();
        load_std();
        loop_sel = 1'b0; en = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (k == 41) en = 1'b0;
            tick();
            obs = {period_o, pluck_o, step_o, busy_o, done_o};
            compared++;
            if (obs !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL one_shot k=%0d got=%h want=%h", k, obs, exp_vec());
            end
            dones += int'(done_o);
            highs += int'(pluck_o);
            if (k == 15) begin
                compared++;
                if (period_o !== 8'd40 || pluck_o !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL rest_step period=%0d pluck=%b want 40/0", period_o, pluck_o);
                end
            end
            if (k == 40) begin
                compared++;
                if (done_o !== 1'b1 || busy_o !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL done_at_40 done=%b busy=%b want 1/0", done_o, busy_o);
                end
            end
        end
        compared++;
        if (dones != 1 || highs != 9) begin
            mismatched++;
            $display("[TB] FAIL one_shot_counts dones=%0d highs=%0d want 1/9", dones, highs);
        end
    endtask

    task automatic test_loop();
        logic [VW-1:0] obs;
        do_reset();
        load_std();
        loop_sel = 1'b1; en = 1'b1;
        for (int k = 0; k < 112; k++) begin
            if (k == 100) en = 1'b0;
            tick();
            obs = {period_o, pluck_o, step_o, busy_o, done_o};
            compared++;
            if (obs !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL loop k=%0d got=%h want=%h", k, obs, exp_vec());
            end
            if (k == 0 || k == 40) begin
                compared++;
                if (pluck_o !== 1'b1 || step_o !== 3'd0 || busy_o !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL loop_wrap k=%0d pluck=%b step=%0d busy=%b want 1/0/1", k, pluck_o, step_o, busy_o);
                end
            end
        end
        compared++;
        if (busy_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL loop_stop busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_pluck_len();
        logic [VW-1:0] obs;
        int highs;
        int n;
        int want;
        for (int c = 0; c < 2; c++) begin
            do_reset();
            load_std();
            loop_sel  = 1'b0;
            tempo     = (c == 0) ? 16'd9 : 16'd4;
            pluck_len = (c == 0) ? 4'd0 : 4'd15;
            want      = (c == 0) ? 3 : 12;
            n = (int'(tempo) + 1) * 4;
            highs = 0;
            en = 1'b1;
            for (int k = 0; k < n + 6; k++) begin
                if (k == n + 1) en = 1'b0;
                tick();
                obs = {period_o, pluck_o, step_o, busy_o, done_o};
                compared++;
                if (obs !== exp_vec()) begin
                    mismatched++;
                    $display("[TB] FAIL pluck_len c=%0d k=%0d got=%h want=%h", c, k, obs, exp_vec());
                end
                highs += int'(pluck_o);
            end
            compared++;
            if (highs != want) begin
                mismatched++;
                $display("[TB] FAIL pluck_len_highs c=%0d got=%0d want=%0d", c, highs, want);
            end
        end
    endtask

    task automatic test_en_drop();
        logic [VW-1:0] obs;
        int max_step = 0;
        int dones = 0;
        do_reset();
        load_std();
        loop_sel = 1'b1; en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 13) en = 1'b0;
            tick();
            obs = {period_o, pluck_o, step_o, busy_o, done_o};
            compared++;
            if (obs !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL en_drop k=%0d got=%h want=%h", k, obs, exp_vec());
            end
            if (busy_o && int'(step_o) > max_step) max_step = int'(step_o);
            dones += int'(done_o);
            if (k == 19 || k == 20) begin
                compared++;
                if (busy_o !== (k == 19) || step_o !== 3'd1) begin
                    mismatched++;
                    $display("[TB] FAIL en_drop_edge k=%0d busy=%b step=%0d want %b/1", k, busy_o, step_o, k == 19);
                end
            end
        end
        compared++;
        if (max_step != 1 || dones != 0) begin
            mismatched++;
            $display("[TB] FAIL en_drop_summary max_step=%0d dones=%0d want 1/0", max_step, dones);
        end
    endtask

    task automatic test_write_collision();
        logic [VW-1:0] obs;
        do_reset();
        load_std();
        loop_sel = 1'b1; en = 1'b1;
        for (int k = 0; k < 122; k++) begin
            wr_en = 1'b0;
            if (k == 13) begin wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'd99; end
            if (k == 60) begin wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'd77; end
            if (k == 110) en = 1'b0;
            tick();
            obs = {period_o, pluck_o, step_o, busy_o, done_o};
            compared++;
            if (obs !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL collision k=%0d got=%h want=%h", k, obs, exp_vec());
            end
            if (k == 20 || k == 60 || k == 100) begin
                compared++;
                if (period_o !== ((k == 100) ? 8'd77 : 8'd99) || step_o !== 3'd2) begin
                    mismatched++;
                    $display("[TB] FAIL collision_period k=%0d got=%0d step=%0d want %0d/2", k, period_o, step_o, (k == 100) ? 77 : 99);
                end
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] obs;
        int highs = 0;
        do_reset();
        load_std();
        loop_sel = 1'b1; en = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs = {period_o, pluck_o, step_o, busy_o, done_o};
        compared++;
        if (obs !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_outputs got=%h want=0", obs);
        end
        for (int k = 0; k < 50; k++) begin
            if (k == 45) en = 1'b0;
            tick();
            obs = {period_o, pluck_o, step_o, busy_o, done_o};
            compared++;
            if (obs !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL reset_mid k=%0d got=%h want=%h", k, obs, exp_vec());
            end
            highs += int'(pluck_o);
        end
        compared++;
        if (highs != 0 || period_o !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_cleared highs=%0d period=%0d want 0/0", highs, period_o);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] obs;
        do_reset();
        en = 1'b1; loop_sel = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 29) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0) loop_sel = ~loop_sel;
            tempo     = TW'($urandom_range(0, 6));
            pluck_len = PW'($urandom_range(0, 15));
            last_step = SW'($urandom_range(0, NS - 1));
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = SW'($urandom_range(0, NS - 1));
            wr_data   = ($urandom_range(0, 2) == 0) ? 8'd0 : DW'($urandom_range(1, 255));
            rst       = ($urandom_range(0, 299) == 0);
            tick();
            obs = {period_o, pluck_o, step_o, busy_o, done_o};
            compared++;
            if (obs !== exp_vec()) begin
                mismatched++;
                $display("[TB] FAIL random k=%0d got=%h want=%h", k, obs, exp_vec());
            end
        end
        rst = 1'b0; wr_en = 1'b0; en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; loop_sel = 1'b0; tempo = '0; pluck_len = '0;
        last_step = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        $display("[TB] ks_note_sequencer bench starting");
        test_reset();
        test_one_shot();
        test_loop();
        test_pluck_len();
        test_en_drop();
        test_write_collision();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
